// File: rtl/cache_pkg.sv
// Shared constants and the fill state encoding for the cache line-fill engine.
package cache_pkg;

  localparam int LINE_W         = 256;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_SEL_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    WRITE
  } fill_state_t;

endpackage

// File: rtl/cache_linefill.sv
// Line-fill engine: fetches one 32-byte line as a critical-word-first wrapping
// burst, forwards the critical word early and writes the line into the line RAM.
module cache_linefill
  import cache_pkg::*;
#(
  parameter int NL  = 128,
  parameter int LSS = $clog2(NL)
) (
  input  logic                  nGCLK,
  input  logic                  RESET,
  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fill_err,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_valid,
  input  logic [WORD_W-1:0]     mem_rdata,
  input  logic                  mem_err,
  output logic                  crit_valid,
  output logic [WORD_W-1:0]     crit_data,
  output logic [LSS-1:0]        write_sel,
  output logic [LINE_W-1:0]     write_port,
  output logic                  wr_ena
);

  fill_state_t           state;
  logic [WORD_SEL_W-1:0] beat_cnt;
  logic [WORD_SEL_W-1:0] start_word;
  logic [WORD_SEL_W-1:0] word_idx;
  logic                  unused_addr_lsb;

  // The wrap within the line falls out of the 3-bit add overflowing.
  assign word_idx        = start_word + beat_cnt;
  assign unused_addr_lsb = ^miss_addr[1:0];

  // write_port doubles as the line buffer, so the RAM sees it directly.
  always_ff @(posedge nGCLK) begin
    if (RESET) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      start_word <= '0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
      write_sel  <= '0;
      write_port <= '0;
      wr_ena     <= 1'b0;
    end else begin
      crit_valid <= 1'b0;
      fill_err   <= 1'b0;
      fill_done  <= 1'b0;
      wr_ena     <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_req) begin
            mem_addr   <= {miss_addr[31:2], 2'b00};
            write_sel  <= miss_addr[LSS+4:5];
            start_word <= miss_addr[4:2];
            beat_cnt   <= '0;
            mem_req    <= 1'b1;
            fill_busy  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (mem_valid) begin
            if (mem_err) begin
              fill_err  <= 1'b1;
              fill_busy <= 1'b0;
              state     <= IDLE;
            end else begin
              write_port[{word_idx, 5'b00000} +: WORD_W] <= mem_rdata;
              beat_cnt <= beat_cnt + 1'b1;
              if (beat_cnt == '0) begin
                crit_data  <= mem_rdata;
                crit_valid <= 1'b1;
              end
              if (beat_cnt == WORD_SEL_W'(WORDS_PER_LINE - 1)) begin
                wr_ena    <= 1'b1;
                fill_done <= 1'b1;
                state     <= WRITE;
              end
            end
          end
        end
        WRITE: begin
          fill_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
